// File: rtl/mixer_seq_ctrl.sv
// Upconversion mixer sequencer: one shared signed 25x25 multiplier computes
// sample*LO, then (sample*LO)*ampl, with valid/ready on both sides.
module mixer_seq_ctrl #(
  parameter int unsigned       W_DATA   = 20,
  parameter int unsigned       W_AMPL   = 25,
  parameter logic [W_AMPL-1:0] AMPL_RST = 25'h028619A,
  parameter int unsigned       SH1      = 15,
  parameter int unsigned       SH2      = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] interp_i,
  input  logic [W_DATA-1:0] lo_i,
  input  logic              ampl_wr,
  input  logic [W_AMPL-1:0] ampl_i,
  output logic              mix_valid,
  input  logic              out_ready,
  output logic [W_DATA-1:0] mix_o,
  output logic              busy,
  output logic [15:0]       sample_cnt
);

  localparam int unsigned W_OP   = 25;
  localparam int unsigned W_PROD = 2 * W_OP;

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

  state_t                   state;
  state_t                   next_state;
  logic [W_DATA-1:0]        sample_q;
  logic [W_DATA-1:0]        lo_q;
  logic [W_DATA-1:0]        inter_q;
  logic [W_AMPL-1:0]        ampl_shadow;
  logic [W_AMPL-1:0]        ampl_active;
  logic signed [W_OP-1:0]   op_a;
  logic signed [W_OP-1:0]   op_b;
  logic signed [W_PROD-1:0] product;
  logic                     accept;

  // Ready only in IDLE and never while reset is held.
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Single multiplier; operands steered by state and sign-extended to 25 bits.
  assign product = op_a * op_b;

  always_comb begin
    next_state = state;
    op_a       = '0;
    op_b       = '0;
    case (state)
      IDLE: if (accept) next_state = MUL1;
      MUL1: begin
        op_a       = W_OP'($signed(sample_q));
        op_b       = W_OP'($signed(lo_q));
        next_state = MUL2;
      end
      MUL2: begin
        op_a       = W_OP'($signed(inter_q));
        op_b       = W_OP'($signed(ampl_active));
        next_state = OUT;
      end
      OUT: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Arithmetic shift then truncate: floor toward -inf, wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sample_q    <= '0;
      lo_q        <= '0;
      inter_q     <= '0;
      mix_o       <= '0;
      mix_valid   <= 1'b0;
      sample_cnt  <= '0;
      ampl_shadow <= AMPL_RST;
      ampl_active <= AMPL_RST;
    end else begin
      state     <= next_state;
      mix_valid <= (next_state == OUT);
      if (ampl_wr) ampl_shadow <= ampl_i;
      if (accept) begin
        sample_q    <= interp_i;
        lo_q        <= lo_i;
        ampl_active <= ampl_wr ? ampl_i : ampl_shadow;
      end
      if (state == MUL1) inter_q <= W_DATA'(product >>> SH1);
      if (state == MUL2) mix_o   <= W_DATA'(product >>> SH2);
      if ((state == OUT) && out_ready) sample_cnt <= sample_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mixer_seq_ctrl.sv
// Directed bench for mixer_seq_ctrl: latency, arithmetic, amplitude buffering,
// output stall, mid-operation reset and a streaming run against a golden model.
module tb_mixer_seq_ctrl;

  localparam logic [24:0] AMPL_RST = 25'h028619A;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] interp_i;
  logic [19:0] lo_i;
  logic        ampl_wr;
  logic [24:0] ampl_i;
  logic        mix_valid;
  logic        out_ready;
  logic [19:0] mix_o;
  logic        busy;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  mixer_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .interp_i  (interp_i),
    .lo_i      (lo_i),
    .ampl_wr   (ampl_wr),
    .ampl_i    (ampl_i),
    .mix_valid (mix_valid),
    .out_ready (out_ready),
    .mix_o     (mix_o),
    .busy      (busy),
    .sample_cnt(sample_cnt)
  );

  function automatic logic [19:0] model(input logic [19:0] s, input logic [19:0] l,
                                        input logic [24:0] a);
    longint      p1;
    longint      p2;
    logic [19:0] inter;
    p1    = longint'($signed(s)) * longint'($signed(l));
    inter = 20'(p1 >>> 15);
    p2    = longint'($signed(inter)) * longint'($signed(a));
    return 20'(p2 >>> 23);
  endfunction

  // Present one sample (optionally with an amplitude write) and wait for its accept edge.
  task automatic send(input logic [19:0] s, input logic [19:0] l,
                      input logic wr, input logic [24:0] a);
    @(negedge clk);
    interp_i = s; lo_i = l; in_valid = 1'b1; ampl_wr = wr; ampl_i = a;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      $display("FAIL send_timeout in_ready got %0b want 1", in_ready);
      $fatal(1, "accept timeout");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; ampl_wr = 1'b0;
  endtask

  // Count negedges until mix_valid rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mix_valid && lat < 20);
    if (!mix_valid) begin
      $display("FAIL valid_timeout mix_valid got 0 want 1 after %0d cycles", lat);
      $fatal(1, "output timeout");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; interp_i = '0; lo_i = '0;
    ampl_wr = 1'b0; ampl_i = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL rst_mix_valid got %0b want 0", mix_valid); end
    checks++; if (mix_o !== 20'h0) begin errors++; $display("FAIL rst_mix_o got %h want 0", mix_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (sample_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %0d want 0", sample_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %0b want 1", in_ready); end
    exp_cnt = '0;
  endtask

  task automatic test_basic();
    int lat;
    send(20'h08000, 20'h08000, 1'b0, '0);
    wait_valid(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
    checks++; if (mix_o !== 20'h02861) begin errors++; $display("FAIL basic_mix_o got %h want 02861", mix_o); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready got %0b want 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy); end
    @(posedge clk); #1;
    exp_cnt++;
    checks++; if (sample_cnt !== exp_cnt) begin errors++; $display("FAIL basic_cnt got %0d want %0d", sample_cnt, exp_cnt); end
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0b want 0", mix_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %0b want 0", busy); end
  endtask

  task automatic test_negative();
    int lat;
    send(20'hF8000, 20'h08000, 1'b0, '0);
    wait_valid(lat);
    checks++; if (mix_o !== 20'hFD79E) begin errors++; $display("FAIL neg_mix_o got %h want FD79E", mix_o); end
    @(posedge clk); #1; exp_cnt++;
  endtask

  task automatic test_ampl_midflight();
    int lat;
    send(20'h08000, 20'h08000, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    ampl_wr = 1'b1; ampl_i = 25'h0800000;
    @(posedge clk); #1; ampl_wr = 1'b0;
    wait_valid(lat);
    checks++; if (mix_o !== 20'h02861) begin errors++; $display("FAIL ampl_inflight got %h want 02861", mix_o); end
    @(posedge clk); #1; exp_cnt++;
    send(20'h08000, 20'h08000, 1'b0, '0);
    wait_valid(lat);
    checks++; if (mix_o !== 20'h08000) begin errors++; $display("FAIL ampl_next got %h want 08000", mix_o); end
    @(posedge clk); #1; exp_cnt++;
  endtask

  task automatic test_stall();
    int lat;
    out_ready = 1'b0;
    send(20'h08000, 20'h08000, 1'b0, '0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (mix_o !== 20'h08000 || mix_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold got %h/%0b want 08000/1", mix_o, mix_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b want 0", in_ready); end
      checks++; if (sample_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt got %0d want %0d", sample_cnt, exp_cnt); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1; exp_cnt++;
    checks++; if (sample_cnt !== exp_cnt) begin errors++; $display("FAIL stall_release_cnt got %0d want %0d", sample_cnt, exp_cnt); end
  endtask

  task automatic test_ampl_on_accept();
    int lat;
    send(20'h08000, 20'h08000, 1'b1, 25'h1C00000);
    wait_valid(lat);
    checks++; if (mix_o !== 20'hFC000) begin errors++; $display("FAIL ampl_accept got %h want FC000", mix_o); end
    @(posedge clk); #1; exp_cnt++;
  endtask

  task automatic test_reset_midop();
    int lat;
    send(20'h08000, 20'h08000, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", mix_valid); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
    checks++; if (sample_cnt !== 16'h0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", sample_cnt); end
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_after got %0b want 0", mix_valid); end
    send(20'h08000, 20'h08000, 1'b0, '0);
    wait_valid(lat);
    checks++; if (mix_o !== 20'h02861) begin errors++; $display("FAIL midrst_ampl got %h want 02861", mix_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_q[$];
    logic [19:0] want;
    bit          acc;
    int          n_in = 0;
    int          n_out = 0;
    int          last = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (sample_cnt !== 16'h0) begin errors++; $display("FAIL b2b_cnt_start got %0d want 0", sample_cnt); end
    out_ready = 1'b1;
    interp_i = 20'h80000; lo_i = 20'h80000; in_valid = 1'b1;
    for (int cyc = 0; cyc < 6000 && n_out < 1000; cyc++) begin
      @(negedge clk);
      if (mix_valid) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
        checks++; if (mix_o !== want) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", n_out, mix_o, want); end
        if (n_out > 0) begin
          checks++; if (cyc - last != 4) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 4", n_out, cyc - last); end
        end
        last = cyc;
        n_out++;
      end
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(model(interp_i, lo_i, AMPL_RST));
      @(posedge clk); #1;
      if (acc) begin
        n_in++;
        case (n_in)
          1: begin interp_i = 20'h7FFFF; lo_i = 20'h7FFFF; end
          2: begin interp_i = 20'h80000; lo_i = 20'h7FFFF; end
          3: begin interp_i = 20'hFFFFF; lo_i = 20'h00001; end
          default: begin interp_i = 20'($urandom); lo_i = 20'($urandom); end
        endcase
        if (n_in >= 1000) in_valid = 1'b0;
      end
    end
    checks++; if (n_out != 1000) begin errors++; $display("FAIL b2b_count got %0d want 1000", n_out); end
    checks++; if (sample_cnt !== 16'd1000) begin errors++; $display("FAIL b2b_sample_cnt got %0d want 1000", sample_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_ampl_midflight();
    test_stall();
    test_ampl_on_accept();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
